// File: rtl/mat_vec_loader.sv
//------------------------------------------------------------------------------
// Module   : mat_vec_loader
// Purpose  : Host-side feeder/collector for the 8-lane matrix-vector
//            multiplier. On start it clears the multiplier accumulators,
//            reads an 8x8 matrix A (8 row words) and vector B (1 word) from
//            word-addressed memory, pushes A column by column together with
//            B[j] into the multiplier FIFOs, waits for a rising edge of the
//            multiplier done level and latches the eight results.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            start, base_addr        - operation request and A row-0 address
//            busy, done, result[7:0] - status and latched results
//            mem_*                   - read-only memory master, one read
//                                      outstanding at a time
//            mvm_clr, mvm_a_*/mvm_b_* - accumulator clear and FIFO writes
//            mvm_done, mvm_out[7:0]  - multiplier done level and results
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mat_vec_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [3*DATA_WIDTH-1:0]   result [7:0],
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic                      mem_read,
  input  logic                      mem_waitrequest,
  input  logic [8*DATA_WIDTH-1:0]   mem_readdata,
  input  logic                      mem_readdatavalid,
  output logic                      mvm_clr,
  output logic                      mvm_a_wren,
  output logic [DATA_WIDTH-1:0]     mvm_a_fifo_in [7:0],
  output logic                      mvm_b_wren,
  output logic [DATA_WIDTH-1:0]     mvm_b_fifo_in,
  input  logic                      mvm_done,
  input  logic [3*DATA_WIDTH-1:0]   mvm_out [7:0]
);

  localparam int WORD_W = 8 * DATA_WIDTH;
  localparam int RES_W  = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT      = 3'd2,
    S_PUSH      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CAPTURE   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              k_q, k_d;           // word counter 0..8
  logic [2:0]              j_q, j_d;           // column counter 0..7
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    done_prev_q, done_prev_d;
  logic [WORD_W-1:0]       rows_q [7:0];
  logic [WORD_W-1:0]       rows_d [7:0];
  logic [WORD_W-1:0]       bvec_q, bvec_d;
  logic [RES_W-1:0]        result_q [7:0];
  logic [RES_W-1:0]        result_d [7:0];

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic                    mvm_clr_q, mvm_clr_d;
  logic                    a_wren_q, a_wren_d;
  logic                    b_wren_q, b_wren_d;
  logic [DATA_WIDTH-1:0]   a_fifo_q [7:0];
  logic [DATA_WIDTH-1:0]   a_fifo_d [7:0];
  logic [DATA_WIDTH-1:0]   b_fifo_q, b_fifo_d;

  // Column presented on the FIFO inputs in the next cycle and the B word it
  // comes from (the B word is bypassed from memory on the first column since
  // it arrives in the same cycle the push starts).
  logic [2:0]              col;
  logic [WORD_W-1:0]       bsrc;
  logic                    push_load;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign next_addr = base_q + {{(ADDR_WIDTH-4){1'b0}}, k_q + 4'd1};

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    j_d           = j_q;
    base_d        = base_q;
    done_prev_d   = done_prev_q;
    rows_d        = rows_q;
    bvec_d        = bvec_q;
    result_d      = result_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    mem_read_d    = 1'b0;
    mem_address_d = '0;
    mvm_clr_d     = 1'b0;
    a_wren_d      = 1'b0;
    b_wren_d      = 1'b0;
    b_fifo_d      = '0;
    for (int i = 0; i < 8; i++) begin
      a_fifo_d[i] = '0;
    end
    col       = 3'd0;
    bsrc      = bvec_q;
    push_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d        = base_addr;
          k_d           = 4'd0;
          done_prev_d   = mvm_done;
          busy_d        = 1'b1;
          mvm_clr_d     = 1'b1;
          mem_read_d    = 1'b1;
          mem_address_d = base_addr;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_waitrequest) begin
          mem_read_d    = 1'b1;
          mem_address_d = mem_address_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          if (k_q == 4'd8) begin
            bvec_d    = mem_readdata;
            bsrc      = mem_readdata;
            j_d       = 3'd0;
            col       = 3'd0;
            push_load = 1'b1;
            state_d   = S_PUSH;
          end else begin
            rows_d[k_q[2:0]] = mem_readdata;
            k_d              = k_q + 4'd1;
            mem_read_d       = 1'b1;
            mem_address_d    = next_addr;
            state_d          = S_REQ;
          end
        end
      end
      S_PUSH: begin
        if (j_q == 3'd7) begin
          state_d = S_WAIT_DONE;
        end else begin
          j_d       = j_q + 3'd1;
          col       = j_q + 3'd1;
          push_load = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        done_prev_d = mvm_done;
        // Only a fresh rising edge counts; a level left high by a previous
        // run was captured into done_prev at start.
        if (mvm_done && !done_prev_q) begin
          result_d = mvm_out;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lane i gets A[i][col]: byte col of row word i (transpose on the fly).
    if (push_load) begin
      a_wren_d = 1'b1;
      b_wren_d = 1'b1;
      b_fifo_d = bsrc[int'(col)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < 8; i++) begin
        a_fifo_d[i] = rows_d[i][int'(col)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      j_q           <= '0;
      base_q        <= '0;
      done_prev_q   <= 1'b0;
      bvec_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      mvm_clr_q     <= 1'b0;
      a_wren_q      <= 1'b0;
      b_wren_q      <= 1'b0;
      b_fifo_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        rows_q[i]   <= '0;
        result_q[i] <= '0;
        a_fifo_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      j_q           <= j_d;
      base_q        <= base_d;
      done_prev_q   <= done_prev_d;
      bvec_q        <= bvec_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      mvm_clr_q     <= mvm_clr_d;
      a_wren_q      <= a_wren_d;
      b_wren_q      <= b_wren_d;
      b_fifo_q      <= b_fifo_d;
      for (int i = 0; i < 8; i++) begin
        rows_q[i]   <= rows_d[i];
        result_q[i] <= result_d[i];
        a_fifo_q[i] <= a_fifo_d[i];
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign mem_address   = mem_address_q;
  assign mem_read      = mem_read_q;
  assign mvm_clr       = mvm_clr_q;
  assign mvm_a_wren    = a_wren_q;
  assign mvm_a_fifo_in = a_fifo_q;
  assign mvm_b_wren    = b_wren_q;
  assign mvm_b_fifo_in = b_fifo_q;

endmodule

`default_nettype wire

// File: tb/tb_mat_vec_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_mat_vec_loader
// Purpose  : Directed self-checking bench for mat_vec_loader with a
//            behavioural memory and multiplier model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mat_vec_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done;
  logic [23:0] result [7:0];
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [63:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic        mvm_clr, mvm_a_wren, mvm_b_wren;
  logic [7:0]  mvm_a_fifo_in [7:0];
  logic [7:0]  mvm_b_fifo_in;
  logic        mvm_done = 1'b0;
  logic [23:0] mvm_out [7:0];

  mat_vec_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .result(result),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .mvm_clr(mvm_clr), .mvm_a_wren(mvm_a_wren), .mvm_a_fifo_in(mvm_a_fifo_in),
    .mvm_b_wren(mvm_b_wren), .mvm_b_fifo_in(mvm_b_fifo_in),
    .mvm_done(mvm_done), .mvm_out(mvm_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Memory image: words img_base+0..7 = A rows, img_base+8 = B.
  logic [63:0] img [0:8];
  logic [31:0] img_base = '0;
  logic [31:0] stall_addr = '0;
  int          stall_left = 0;

  function automatic logic [63:0] word_at(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - img_base;
    if (off < 32'd9) return img[off];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  // Per-run observation counters (reset by the stimulus and on mvm_clr).
  int          n_rd = 0, n_wr = 0, n_bwr = 0, n_done = 0, clr_cnt = 0;
  int          lane_bad = 0, first_wr_cyc = 0, rise_cyc = -10, dn_timer = 0;
  logic [31:0] rd_addr [0:15];
  logic        pend = 1'b0, stalled_prev = 1'b0;
  logic [31:0] pend_addr = '0;
  int          acc [0:7];

  initial begin
    for (int i = 0; i < 8; i++) mvm_out[i] = '0;
    for (int i = 0; i < 8; i++) acc[i] = 0;
  end

  // Memory, multiplier model and bus monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    // Read data for the request accepted at the preceding rising edge.
    mem_readdatavalid = pend;
    mem_readdata      = pend ? word_at(pend_addr) : 64'd0;

    if (stalled_prev) begin
      chk("stall_hold_read", {63'd0, mem_read}, 64'd1);
      chk("stall_hold_addr", {32'd0, mem_address}, {32'd0, stall_addr});
    end
    mem_waitrequest = 1'b0;
    if (mem_read && stall_left > 0 && mem_address == stall_addr) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end
    stalled_prev = mem_waitrequest;
    pend         = mem_read && !mem_waitrequest;
    pend_addr    = mem_address;
    if (pend) begin
      if (n_rd < 16) rd_addr[n_rd] = mem_address;
      n_rd++;
    end

    // Multiplier: done falls, then rises a few cycles after the 8th write.
    if (dn_timer > 0) begin
      dn_timer++;
      if (dn_timer == 3) mvm_done = 1'b0;
      if (dn_timer == 6) begin
        for (int i = 0; i < 8; i++) mvm_out[i] = 24'(acc[i]);
        mvm_done = 1'b1;
        rise_cyc = cyc;
        dn_timer = 0;
      end
    end
    if (mvm_clr) begin
      clr_cnt++;
      for (int i = 0; i < 8; i++) acc[i] = 0;
      dn_timer = 0;
    end
    if (mvm_b_wren) n_bwr++;
    if (mvm_a_wren) begin
      if (n_wr == 0) first_wr_cyc = cyc;
      if (n_wr >= 8) lane_bad++;
      else begin
        for (int i = 0; i < 8; i++) begin
          if (mvm_a_fifo_in[i] !== img[i][8*n_wr +: 8]) lane_bad++;
          acc[i] += int'(mvm_a_fifo_in[i]) * int'(mvm_b_fifo_in);
        end
        if (mvm_b_fifo_in !== img[8][8*n_wr +: 8]) lane_bad++;
      end
      n_wr++;
      if (n_wr == 8) dn_timer = 1;
    end

    if (done) begin
      n_done++;
      chk("done_after_rise", 64'(cyc), 64'(rise_cyc + 1));
      chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    end
  end

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_bwr = 0; n_done = 0; clr_cnt = 0; lane_bad = 0;
  endtask

  // Launch one operation and wait (bounded) for done.
  task automatic run_op(input string nm, input logic [31:0] base,
                        input bit restart, input bit timing);
    int c0, t;
    img_base  = base;
    base_addr = base;
    clear_counts();
    start = 1'b1;
    c0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (timing) begin
      chk({nm, "_c1_busy"}, {63'd0, busy}, 64'd1);
      chk({nm, "_c1_clr"}, {63'd0, mvm_clr}, 64'd1);
      chk({nm, "_c1_read"}, {63'd0, mem_read}, 64'd1);
      chk({nm, "_c1_addr"}, {32'd0, mem_address}, {32'd0, base});
    end
    t = 0;
    while (!done && t < 1000) begin
      start = restart && (mvm_a_wren || (n_wr == 8 && busy));
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, {63'd0, done}, 64'd1);
    if (timing) chk({nm, "_push_cycle"}, 64'(first_wr_cyc - c0), 64'd19);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_reads"}, 64'(n_rd), 64'd9);
    chk({nm, "_a_writes"}, 64'(n_wr), 64'd8);
    chk({nm, "_b_writes"}, 64'(n_bwr), 64'd8);
    chk({nm, "_done_count"}, 64'(n_done), 64'd1);
    chk({nm, "_clr_count"}, 64'(clr_cnt), 64'd1);
    chk({nm, "_lane_data_errs"}, 64'(lane_bad), 64'd0);
  endtask

  task automatic chk_results(input string nm, input int e0, input int step);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_result%0d", nm, i), {40'd0, result[i]}, 64'(e0 + step * i));
  endtask

  initial begin
    for (int r = 0; r < 9; r++) img[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_read", {63'd0, mem_read}, 64'd0);
    chk("rst_addr", {32'd0, mem_address}, 64'd0);
    chk("rst_wren", {62'd0, mvm_a_wren, mvm_b_wren}, 64'd0);
    chk("rst_result7", {40'd0, result[7]}, 64'd0);
    @(posedge clk); #1;

    // T1: A[i][j]=i+1, B[j]=1 -> 8*(i+1)
    for (int r = 0; r < 8; r++) img[r] = {8{8'(r + 1)}};
    img[8] = {8{8'h01}};
    run_op("t1", 32'h0000_1000, 1'b0, 1'b1);
    chk_results("t1", 8, 8);

    // T2: everything 255 -> 8*255*255 = 520200
    for (int r = 0; r < 9; r++) img[r] = {8{8'hFF}};
    run_op("t2", 32'h0000_2000, 1'b0, 1'b0);
    chk_results("t2", 520200, 0);

    // T3: three stall cycles on word 4, data as T1
    for (int r = 0; r < 8; r++) img[r] = {8{8'(r + 1)}};
    img[8]     = {8{8'h01}};
    stall_addr = 32'h0000_3004;
    stall_left = 3;
    run_op("t3", 32'h0000_3000, 1'b0, 1'b0);
    chk("t3_stall_used", 64'(stall_left), 64'd0);
    chk_results("t3", 8, 8);

    // T4: wrapping base, restart pulses; A[i][j]=i+j, B[j]=j+1 -> 36i+168
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][8*c +: 8] = 8'(r + c);
    for (int c = 0; c < 8; c++) img[8][8*c +: 8] = 8'(c + 1);
    run_op("t4", 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("t4_addr4", {32'd0, rd_addr[4]}, 64'h0000_0000);
    chk("t4_addr8", {32'd0, rd_addr[8]}, 64'h0000_0004);
    chk_results("t4", 168, 36);

    // T5: mvm_done still high from T4; A=2, B[j]=j -> 56
    for (int r = 0; r < 8; r++) img[r] = {8{8'h02}};
    for (int c = 0; c < 8; c++) img[8][8*c +: 8] = 8'(c);
    run_op("t5", 32'h0000_5000, 1'b0, 1'b0);
    chk_results("t5", 56, 0);

    // T6: reset on the 4th push cycle, then a fresh diagonal run -> 3*(i+1)
    for (int r = 0; r < 8; r++) img[r] = {8{8'(r + 1)}};
    img[8]    = {8{8'h01}};
    img_base  = 32'h0000_6000;
    base_addr = 32'h0000_6000;
    clear_counts();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int t;
      t = 0;
      while (!(mvm_a_wren && n_wr == 3) && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      chk("t6_reached_push4", {63'd0, mvm_a_wren}, 64'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_wren", {62'd0, mvm_a_wren, mvm_b_wren}, 64'd0);
    chk("t6_rst_lane3", {56'd0, mvm_a_fifo_in[3]}, 64'd0);
    chk("t6_rst_bfifo", {56'd0, mvm_b_fifo_in}, 64'd0);
    chk("t6_rst_read", {63'd0, mem_read}, 64'd0);
    chk("t6_rst_result0", {40'd0, result[0]}, 64'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_more_writes", 64'(n_wr), 64'd4);
    chk("t6_idle_busy", {63'd0, busy}, 64'd0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][8*c +: 8] = (r == c) ? 8'd3 : 8'd0;
    for (int c = 0; c < 8; c++) img[8][8*c +: 8] = 8'(c + 1);
    run_op("t6b", 32'h0000_7000, 1'b0, 1'b1);
    chk_results("t6b", 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mat_vec_loader.md
# mat_vec_loader

- Host-side feeder and collector for the 8-lane matrix-vector multiplier.
- On `start` it:
  - clears the multiplier accumulators;
  - fetches an 8x8 matrix A and an 8-element vector B from word-addressed memory;
  - transposes A into column order and writes A and B into the multiplier's input FIFOs;
  - waits for the multiplier's `done`, then latches the eight 24-bit results.
- It is the writer/controller end of the multiplier's FIFO interface.

## Interface
- `DATA_WIDTH`, 8, element width; memory word = 8*DATA_WIDTH bits, result = 3*DATA_WIDTH bits.
- `ADDR_WIDTH`, 32, memory word-address width.
- `clk` in 1, single clock, all logic on rising edge.
- `rst` in 1, reset, synchronous and active-high.
- `start` in 1, request one operation; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH, word address of A row 0; captured on accepted `start`.
- `busy` out 1, high from the cycle after accept until the `done` cycle.
- `done` out 1, one-cycle pulse when `result` is updated.
- `result[7:0]` out 3*DATA_WIDTH each, latched multiplier outputs; held until the next capture.
- `mem_address` out ADDR_WIDTH, read address.
- `mem_read` out 1, read request.
- `mem_waitrequest` in 1, memory stall; the request is held while high.
- `mem_readdata` in 8*DATA_WIDTH, read data; byte k (bits 8k+7:8k) = element k.
- `mem_readdatavalid` in 1, `mem_readdata` valid.
- `mvm_clr` out 1, accumulator clear pulse to the multiplier MACs.
- `mvm_a_wren` out 1, write strobe for all eight A FIFOs.
- `mvm_a_fifo_in[7:0]` out DATA_WIDTH each, lane i carries A[i][j].
- `mvm_b_wren` out 1, write strobe for the B FIFO.
- `mvm_b_fifo_in` out DATA_WIDTH, carries B[j].
- `mvm_done` in 1, multiplier done level.
- `mvm_out[7:0]` in 3*DATA_WIDTH each, multiplier results.

## Operation
- Memory layout:
  - words `base_addr`+0..7 hold A rows 0..7, with byte k = A[row][k];
  - word `base_addr`+8 holds B, with byte k = B[k];
  - addresses wrap modulo 2^ADDR_WIDTH.
- States: IDLE, REQ, WAIT, PUSH, WAIT_DONE, CAPTURE.
- IDLE:
  - On `start`=1, capture `base_addr`, clear word counter k=0, register `mvm_done` as `done_prev`, go to REQ.
  - `mvm_clr`=1 for exactly the first REQ cycle.
- REQ:
  - `mem_read`=1, `mem_address`=base+k.
  - Address and read are held stable while `mem_waitrequest`=1.
  - On `mem_waitrequest`=0, go to WAIT.
- WAIT:
  - `mem_read`=0.
  - On `mem_readdatavalid`, store word k: k<8 goes to row buffer k, k=8 goes to the B buffer.
  - Then k<8 → k+1, go to REQ; k=8 → column counter j=0, go to PUSH.
  - Only one read is ever outstanding.
- PUSH:
  - Every cycle assert `mvm_a_wren`=`mvm_b_wren`=1.
  - Drive lane i with `mvm_a_fifo_in[i]`=A[i][j] and drive `mvm_b_fifo_in`=B[j].
  - j increments; after j=7 go to WAIT_DONE. This is exactly 8 writes.
- WAIT_DONE:
  - `done_prev` tracks `mvm_done` every cycle.
  - Leave on a rising edge (`mvm_done`=1 and `done_prev`=0) and go to CAPTURE.
  - A `mvm_done` level still high from a prior run must not trigger capture.
- CAPTURE (1 cycle): `result[i]`<=`mvm_out[i]`, `done`=1, `busy`=0, next state IDLE.
- Ignored inputs:
  - `start` outside IDLE is ignored.
  - `mem_readdatavalid` outside WAIT is ignored.
- All FIFO-side and memory outputs are 0 whenever not in the states named above.
- Reset:
  - State→IDLE; `busy`, `done`, `mem_read`, `mvm_clr`, both wrens, `mvm_*_fifo_in` and `mem_address` = 0; all `result[i]`=0.
  - Reset mid-operation abandons the run with no further writes.
  - A response to a read already accepted by memory is discarded.

## Timing
- `start` sampled in cycle 0 → cycle 1: REQ, `busy`=1, `mvm_clr`=1, `mem_read`=1, address=base.
- Each memory word costs 1 + (waitrequest cycles) + (read latency) cycles. With zero wait and latency 1, each word is 2 cycles, so REQ/WAIT spans cycles 1–18.
- PUSH occupies cycles 19–26 in that case.
- `done` and the new `result` appear together, one cycle after the `mvm_done` rising edge is sampled.
- `busy` drops in the `done` cycle.
- The earliest new `start` is accepted the cycle after `done`.

## Test plan
- A[i][j]=i+1, B[j]=1, zero-wait latency-1 memory with the real multiplier attached → `done` once, `result[i]`=8*(i+1), PUSH seen exactly 8 cycles with lane 3 carrying 4 on every write.
- All elements 255 → every `result[i]`=520200 (8*255*255, no truncation in 24 bits).
- `mem_waitrequest` held high 3 cycles on word 4 → `mem_address`=base+4 and `mem_read` stable across the stall, only 9 reads total, results unchanged from the first case.
- `start` re-pulsed during PUSH and WAIT_DONE → ignored: no extra reads or writes, single `done`. `base_addr`=0xFFFFFFFC → addresses wrap through 0x00000004.
- Second run with `mvm_done` still high from the first run → no capture until `mvm_done` falls and rises again; `mvm_clr` pulses once at run start; results reflect only the new data.
- `rst` asserted on the 4th PUSH cycle → next cycle all outputs 0, state IDLE, no further wren. A following fresh run completes normally.
